alu_cmd_issuer: RTL and testbench

//  Upstream feeder for the 9-bit combinational ALU. Buffers (a, b, sel) commands in a small FIFO.

---
 rtl/alu_cmd_issuer.sv | 119 +++++++++++
 tb/tb_alu_cmd_issuer.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_issuer.sv
// Command FIFO feeding a combinational ALU. Each command is held on registered
// ALU inputs for a full cycle, and its result is returned over a valid/ready handshake.
module alu_cmd_issuer #(
  parameter int W     = 9,
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [W-1:0]  cmd_a,
  input  logic [W-1:0]  cmd_b,
  input  logic [3:0]    cmd_sel,
  output logic [W-1:0]  alu_a,
  output logic [W-1:0]  alu_b,
  output logic [3:0]    alu_sel,
  input  logic [W-1:0]  alu_z,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [W-1:0]  res_z,
  output logic [3:0]    res_sel,
  output logic          res_err,
  output logic [CW-1:0] fifo_count
);

  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [3:0]   sel;
  } cmd_t;

  typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

  cmd_t [DEPTH-1:0] mem;
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;
  state_t           state;
  cmd_t             head;
  logic             push, pop, hs;

  // Ready is held low while reset is asserted so every output reads 0 in reset.
  assign cmd_ready  = rst_n && (count < CW'(DEPTH));
  assign fifo_count = count;
  assign head       = mem[rd_ptr];
  assign push       = cmd_valid && cmd_ready;
  assign hs         = res_valid && res_ready;
  assign pop        = (count != '0) && ((state == IDLE) || (state == DONE && hs));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= '{a: cmd_a, b: cmd_b, sel: cmd_sel};
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_sel   <= '0;
      res_valid <= 1'b0;
      res_z     <= '0;
      res_sel   <= '0;
      res_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (pop) begin
          alu_a   <= head.a;
          alu_b   <= head.b;
          alu_sel <= head.sel;
          state   <= ISSUE;
        end
        ISSUE: begin
          res_valid <= 1'b1;
          res_sel   <= alu_sel;
          // Opcode 4'b1111 has no ALU meaning; report it instead of passing z on.
          if (alu_sel == 4'b1111) begin
            res_z   <= '0;
            res_err <= 1'b1;
          end else begin
            res_z   <= alu_z;
            res_err <= 1'b0;
          end
          state <= DONE;
        end
        DONE: if (hs) begin
          res_valid <= 1'b0;
          if (pop) begin
            alu_a   <= head.a;
            alu_b   <= head.b;
            alu_sel <= head.sel;
            state   <= ISSUE;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Bench for alu_cmd_issuer: a behavioural ALU drives alu_z, a vector table plus
// hand sequences drive commands, and a scoreboard checks every returned result.
module tb_alu_cmd_issuer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid, cmd_ready;
  logic [8:0] cmd_a, cmd_b;
  logic [3:0] cmd_sel;
  logic [8:0] alu_a, alu_b, alu_z;
  logic [3:0] alu_sel;
  logic       res_valid, res_ready;
  logic [8:0] res_z;
  logic [3:0] res_sel;
  logic       res_err;
  logic [2:0] fifo_count;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  alu_cmd_issuer #(.W(9), .DEPTH(4), .CW(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_sel(cmd_sel),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_z(alu_z),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_z(res_z), .res_sel(res_sel), .res_err(res_err),
    .fifo_count(fifo_count)
  );

  // Reference ALU; opcode 15 deliberately returns b so a leaked z is visible.
  function automatic logic [8:0] alu_f(input logic [8:0] a, input logic [8:0] b, input logic [3:0] s);
    case (s)
      4'd0:  return 9'(a + b);
      4'd1:  return 9'(a - b);
      4'd2:  return a & b;
      4'd3:  return a | b;
      4'd4:  return a ^ b;
      4'd5:  return 9'(a << 1);
      4'd6:  return a >> 1;
      4'd7:  return ~a;
      4'd13: return 9'(a + 9'd1);
      4'd14: return a;
      default: return b;
    endcase
  endfunction

  assign alu_z = alu_f(alu_a, alu_b, alu_sel);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [8:0] z;
    logic [3:0] sel;
    logic       err;
  } exp_t;

  exp_t exp_q[$];

  // Scoreboard: expectations enter on accepted commands and leave on result handshakes.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      if (res_valid && res_ready) begin
        if (exp_q.size() == 0) begin
          chk("sb_unexpected_result", 32'(res_z), 32'h1ff_ffff);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("sb_z", 32'(res_z), 32'(e.z));
          chk("sb_sel", 32'(res_sel), 32'(e.sel));
          chk("sb_err", 32'(res_err), 32'(e.err));
        end
      end
      if (cmd_valid && cmd_ready) begin
        exp_t e;
        e.sel = cmd_sel;
        e.err = (cmd_sel == 4'hF);
        e.z   = e.err ? 9'd0 : alu_f(cmd_a, cmd_b, cmd_sel);
        exp_q.push_back(e);
      end
    end
  end

  // All tasks enter and leave 1 time unit after a rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [8:0] a, input logic [8:0] b, input logic [3:0] s);
    logic acc;
    acc = 1'b0;
    cmd_a = a; cmd_b = b; cmd_sel = s; cmd_valid = 1'b1;
    for (int n = 0; n < 200; n++) begin
      acc = cmd_ready;
      step();
      if (acc) break;
    end
    cmd_valid = 1'b0;
    if (!acc) chk("send_timeout", 32'(acc), 32'd1);
  endtask

  task automatic wait_res();
    for (int n = 0; n < 100; n++) begin
      if (res_valid) break;
      step();
    end
    if (!res_valid) chk("res_valid_timeout", 32'(res_valid), 32'd1);
  endtask

  task automatic drain();
    res_ready = 1'b1;
    for (int n = 0; n < 1000; n++) begin
      if (exp_q.size() == 0 && !res_valid) break;
      step();
    end
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  typedef struct {
    logic [8:0] a;
    logic [8:0] b;
    logic [3:0] sel;
    logic [8:0] z;
    logic       err;
  } vec_t;

  vec_t       vecs[12];
  logic [8:0] drain_z[6];

  initial begin
    vecs[0]  = '{a: 9'd5,     b: 9'd7,     sel: 4'd0,  z: 9'd12,    err: 1'b0};
    vecs[1]  = '{a: 9'd9,     b: 9'd4,     sel: 4'd1,  z: 9'd5,     err: 1'b0};
    vecs[2]  = '{a: 9'h01F,   b: 9'h00F,   sel: 4'd2,  z: 9'h00F,   err: 1'b0};
    vecs[3]  = '{a: 9'h0F0,   b: 9'h00F,   sel: 4'd3,  z: 9'h0FF,   err: 1'b0};
    vecs[4]  = '{a: 9'h1FF,   b: 9'h0FF,   sel: 4'd4,  z: 9'h100,   err: 1'b0};
    vecs[5]  = '{a: 9'h100,   b: 9'h000,   sel: 4'd5,  z: 9'h000,   err: 1'b0};
    vecs[6]  = '{a: 9'h1FF,   b: 9'h001,   sel: 4'd0,  z: 9'h000,   err: 1'b0};
    vecs[7]  = '{a: 9'd3,     b: 9'd3,     sel: 4'd15, z: 9'h000,   err: 1'b1};
    vecs[8]  = '{a: 9'h1FF,   b: 9'h000,   sel: 4'd13, z: 9'h000,   err: 1'b0};
    vecs[9]  = '{a: 9'h0AB,   b: 9'h155,   sel: 4'd14, z: 9'h0AB,   err: 1'b0};
    vecs[10] = '{a: 9'h0AB,   b: 9'h001,   sel: 4'd6,  z: 9'h055,   err: 1'b0};
    vecs[11] = '{a: 9'd4,     b: 9'd9,     sel: 4'd1,  z: 9'h1FB,   err: 1'b0};
    drain_z  = '{9'd4, 9'd3, 9'd5, 9'h00F, 9'h000, 9'h0FF};

    rst_n = 1'b0; cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_sel = '0; res_ready = 1'b0;

    // Reset state
    #3;
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_count", 32'(fifo_count), 32'd0);
    chk("rst_alu_a", 32'(alu_a), 32'd0);
    chk("rst_res_z", 32'(res_z), 32'd0);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    step(); step();
    rst_n = 1'b1;
    #1;
    chk("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);
    step();

    // Single add with exact latency
    res_ready = 1'b1;
    send(9'd5, 9'd7, 4'd0);
    chk("lat_count1", 32'(fifo_count), 32'd1);
    chk("lat_valid_t1", 32'(res_valid), 32'd0);
    step();
    chk("lat_alu_a", 32'(alu_a), 32'd5);
    chk("lat_alu_b", 32'(alu_b), 32'd7);
    chk("lat_valid_t2", 32'(res_valid), 32'd0);
    step();
    chk("lat_valid_t3", 32'(res_valid), 32'd1);
    chk("lat_res_z", 32'(res_z), 32'd12);
    chk("lat_res_sel", 32'(res_sel), 32'd0);
    chk("lat_res_err", 32'(res_err), 32'd0);
    step();
    chk("lat_valid_after_hs", 32'(res_valid), 32'd0);

    // Vector table, one command at a time
    for (int i = 0; i < 12; i++) begin
      send(vecs[i].a, vecs[i].b, vecs[i].sel);
      wait_res();
      chk($sformatf("vec%0d_z", i), 32'(res_z), 32'(vecs[i].z));
      chk($sformatf("vec%0d_sel", i), 32'(res_sel), 32'(vecs[i].sel));
      chk($sformatf("vec%0d_err", i), 32'(res_err), 32'(vecs[i].err));
      step();
    end
    drain();

    // Fill under backpressure, then drain at one result per 2 cycles
    res_ready = 1'b0;
    send(9'd2, 9'd2, 4'd0);
    wait_res();
    send(9'd1, 9'd2, 4'd0);
    send(9'd9, 9'd4, 4'd1);
    send(9'h01F, 9'h00F, 4'd2);
    send(9'h100, 9'h000, 4'd5);
    cmd_a = 9'h0AA; cmd_b = 9'h055; cmd_sel = 4'd4; cmd_valid = 1'b1;
    step(); step(); step();
    chk("full_count", 32'(fifo_count), 32'd4);
    chk("full_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("held_res_z", 32'(res_z), 32'd4);
    chk("held_alu_a", 32'(alu_a), 32'd2);
    chk("held_res_valid", 32'(res_valid), 32'd1);
    res_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("drain%0d_valid", k), 32'(res_valid), 32'd1);
      chk($sformatf("drain%0d_z", k), 32'(res_z), 32'(drain_z[k]));
      step();
      chk($sformatf("drain%0d_gap", k), 32'(res_valid), 32'd0);
      if (k == 0) begin
        step();
        cmd_valid = 1'b0;
      end else if (k < 5) begin
        step();
      end
    end
    drain();

    // Illegal opcode followed by a wrapping increment
    res_ready = 1'b1;
    send(9'd3, 9'd3, 4'b1111);
    send(9'h1FF, 9'h000, 4'b1101);
    wait_res();
    chk("illegal_err", 32'(res_err), 32'd1);
    chk("illegal_z", 32'(res_z), 32'd0);
    step();
    wait_res();
    chk("inc_err", 32'(res_err), 32'd0);
    chk("inc_z", 32'(res_z), 32'd0);
    chk("inc_sel", 32'(res_sel), 32'd13);
    step();
    drain();

    // Asynchronous reset while DONE with three commands queued
    res_ready = 1'b0;
    send(9'd1, 9'd1, 4'd0);
    send(9'd2, 9'd1, 4'd0);
    send(9'd3, 9'd1, 4'd0);
    send(9'd4, 9'd1, 4'd0);
    chk("pre_rst_count", 32'(fifo_count), 32'd3);
    chk("pre_rst_valid", 32'(res_valid), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", 32'(res_valid), 32'd0);
    chk("midrst_count", 32'(fifo_count), 32'd0);
    chk("midrst_res_z", 32'(res_z), 32'd0);
    chk("midrst_alu_a", 32'(alu_a), 32'd0);
    chk("midrst_alu_sel", 32'(alu_sel), 32'd0);
    @(negedge clk);
    step();
    rst_n = 1'b1;
    #1;
    chk("midrst_ready_after", 32'(cmd_ready), 32'd1);
    res_ready = 1'b1;
    step(); step(); step(); step();
    chk("midrst_no_result", 32'(res_valid), 32'd0);
    chk("midrst_count_after", 32'(fifo_count), 32'd0);

    // Simultaneous push and pop at count 2
    res_ready = 1'b0;
    send(9'd1, 9'd1, 4'd0);
    wait_res();
    send(9'd5, 9'd2, 4'd1);
    send(9'd6, 9'd3, 4'd2);
    chk("pp_count_before", 32'(fifo_count), 32'd2);
    cmd_a = 9'd7; cmd_b = 9'd1; cmd_sel = 4'd1; cmd_valid = 1'b1;
    res_ready = 1'b1;
    step();
    cmd_valid = 1'b0;
    chk("pp_count_same", 32'(fifo_count), 32'd2);
    drain();

    // Ten back-to-back commands to wrap the pointers
    res_ready = 1'b1;
    for (int i = 0; i < 10; i++)
      send(9'($urandom_range(0, 511)), 9'($urandom_range(0, 511)), 4'($urandom_range(0, 15)));
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
